vga_rom_bitmap_pipe: RTL and testbench

//  Fully pipelined monochrome-bitmap renderer for the VGA path: one pixel per clock at pixel rate.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_pipe_delay.sv | 28 ++
 rtl/vga_rom_bitmap_pipe.sv | 146 ++++++++++++++
 tb/tb_vga_rom_bitmap_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, pipeline constants and stage bundles.
// Used by vga_rom_bitmap_pipe and vga_pipe_delay.
package vga_timing_pkg;

    localparam int CNT_W        = 11;
    localparam int H_START_DEF  = 216;
    localparam int V_START_DEF  = 27;
    localparam int VGA_PIPE_LAT = 3;

    localparam logic [2:0] RGB_BLACK = 3'b000;
    localparam logic [2:0] RGB_WHITE = 3'b111;

    // Window-qualified pixel coordinate plus side-band, as captured in S1.
    typedef struct packed {
        logic             valid;
        logic             en;
        logic             inv;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
    } s1_t;

    // Half-open span test (lo, hi] used for both window axes.
    function automatic logic in_span(
        input logic [CNT_W-1:0] v,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        return (v > lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// Resettable fixed-depth shift register used to keep syncs and
// pixel side-band aligned with the ROM read path.
module vga_pipe_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr [DEPTH];

    // Shift one stage per clock; reset loads every stage with RST_VAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/vga_rom_bitmap_pipe.sv
// Pipelined 1bpp bitmap renderer: counters -> ROM address -> rgb, syncs re-timed.
// Optional macro VGA_BITMAP_SCALE2X_EN enables 2x2 pixel replication.
module vga_rom_bitmap_pipe
    import vga_timing_pkg::*;
#(
    parameter int         IMG_W   = 128,
    parameter int         IMG_H   = 128,
    parameter int         H_START = H_START_DEF,
    parameter int         V_START = V_START_DEF,
    parameter int         X_OFF   = 0,
    parameter int         Y_OFF   = 0,
    parameter int         ADDR_W  = 11,
    parameter logic [2:0] FG_RGB  = RGB_WHITE,
    parameter logic [2:0] BG_RGB  = RGB_BLACK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       c1,
    input  logic [10:0]       c2,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              disp_en,
    input  logic              invert,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [2:0]        rgb,
    output logic              hsync_out,
    output logic              vsync_out
);

`ifdef VGA_BITMAP_SCALE2X_EN
    localparam int SCALE_SH = 1;
`else
    localparam int SCALE_SH = 0;
`endif

    localparam int W_DISP = IMG_W << SCALE_SH;
    localparam int H_DISP = IMG_H << SCALE_SH;

    localparam logic [CNT_W-1:0] H_LO = CNT_W'(H_START + X_OFF);
    localparam logic [CNT_W-1:0] H_HI = CNT_W'(H_START + X_OFF + W_DISP);
    localparam logic [CNT_W-1:0] V_LO = CNT_W'(V_START + Y_OFF);
    localparam logic [CNT_W-1:0] V_HI = CNT_W'(V_START + Y_OFF + H_DISP);

    localparam logic [31:0] BPR = 32'(IMG_W / 8);

    s1_t              s1_nxt;
    s1_t              s1;
    logic [1:0]       sync1;
    logic [CNT_W-1:0] dx;
    logic [CNT_W-1:0] dy;
    logic             in_win;

    logic [5:0]       side_d;
    logic [5:0]       side3;
    logic             valid3;
    logic             en3;
    logic             inv3;
    logic [2:0]       idx3;
    logic [1:0]       sync_q;
    logic             pix;

    assign dx     = c1 - H_LO - 11'd1;
    assign dy     = c2 - V_LO - 11'd1;
    assign in_win = in_span(c1, H_LO, H_HI) && in_span(c2, V_LO, V_HI);

    // S1 next-state: window test and bitmap coordinates (zero outside).
    always_comb begin
        s1_nxt       = '0;
        s1_nxt.valid = in_win;
        s1_nxt.en    = disp_en;
        s1_nxt.inv   = invert;
        if (in_win) begin
            s1_nxt.x = dx >> SCALE_SH;
            s1_nxt.y = dy >> SCALE_SH;
        end
    end

    // S1: capture window-qualified coordinates and raw syncs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= '0;
            sync1 <= 2'b11;
        end else begin
            s1    <= s1_nxt;
            sync1 <= {hsync_in, vsync_in};
        end
    end

    // S2: byte address into the row-major 1bpp ROM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
        end else begin
            rom_addr <= ADDR_W'(32'(s1.y) * BPR + 32'(s1.x >> 3));
        end
    end

    assign side_d = {s1.valid, s1.en, s1.inv, s1.x[2:0]};

    // Side-band rides S2 and S3 so it meets rom_data at S4.
    vga_pipe_delay #(
        .WIDTH  (6),
        .DEPTH  (2),
        .RST_VAL(6'b0)
    ) u_side_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (side_d),
        .q    (side3)
    );

    assign {valid3, en3, inv3, idx3} = side3;

    // Syncs follow S1 through three more stages to land with rgb.
    vga_pipe_delay #(
        .WIDTH  (2),
        .DEPTH  (VGA_PIPE_LAT),
        .RST_VAL(2'b11)
    ) u_sync_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sync1),
        .q    (sync_q)
    );

    assign hsync_out = sync_q[1];
    assign vsync_out = sync_q[0];

    // LSB of each byte is the leftmost pixel of its 8-pixel group.
    assign pix = rom_data[idx3];

    // S4: colour select; blanked outside the window or when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb <= RGB_BLACK;
        end else if (!valid3 || !en3) begin
            rgb <= RGB_BLACK;
        end else if (pix ^ inv3) begin
            rgb <= FG_RGB;
        end else begin
            rgb <= BG_RGB;
        end
    end

endmodule

// File: tb/tb_vga_rom_bitmap_pipe.sv
// Self-checking bench for vga_rom_bitmap_pipe with a behavioural sync ROM.
// Honours VGA_BITMAP_SCALE2X_EN in its reference model.
module tb_vga_rom_bitmap_pipe;

`ifdef VGA_BITMAP_SCALE2X_EN
    localparam int SH = 1;
`else
    localparam int SH = 0;
`endif
    localparam int WD = 128 << SH;
    localparam int HD = 128 << SH;

    typedef struct {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    typedef struct {
        logic [10:0] c1;
        logic [10:0] c2;
        logic        hs;
        logic        vs;
        logic        en;
        logic        inv;
        logic [2:0]  rgb;
        logic [10:0] addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] c1 = '0;
    logic [10:0] c2 = '0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        disp_en = 1'b1;
    logic        invert = 1'b0;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic [2:0]  rgb;
    logic        hsync_out;
    logic        vsync_out;

    logic [7:0]  rom [2048];
    exp_t        rq[$];
    logic [10:0] aq[$];
    int          nvec = 0;
    int          nerr = 0;
    int          whites = 0;
    vec_t        tbl[16];

    vga_rom_bitmap_pipe dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .c1       (c1),
        .c2       (c2),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .disp_en  (disp_en),
        .invert   (invert),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rgb      (rgb),
        .hsync_out(hsync_out),
        .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model(
        input  int          a1,
        input  int          a2,
        input  logic        en,
        input  logic        inv,
        output logic [2:0]  er,
        output logic [10:0] ea
    );
        int   x;
        int   y;
        logic in;
        logic b;
        in = (a1 > 216) && (a1 <= 216 + WD) && (a2 > 27) && (a2 <= 27 + HD);
        x  = in ? (a1 - 217) >> SH : 0;
        y  = in ? (a2 - 28) >> SH : 0;
        ea = 11'(y * 16 + x / 8);
        b  = rom[ea][x % 8];
        er = (!in || !en) ? 3'b000 : ((b ^ inv) ? 3'b111 : 3'b000);
    endfunction

    task automatic step(
        input logic [10:0] a1,
        input logic [10:0] a2,
        input logic        hs,
        input logic        vs,
        input logic        en,
        input logic        inv,
        input logic [2:0]  er,
        input logic [10:0] ea
    );
        exp_t e;
        logic [10:0] a;
        c1 = a1;
        c2 = a2;
        hsync_in = hs;
        vsync_in = vs;
        disp_en = en;
        invert = inv;
        e.rgb = er;
        e.hs = hs;
        e.vs = vs;
        rq.push_back(e);
        aq.push_back(ea);
        @(posedge clk);
        #1;
        if (aq.size() == 2) begin
            a = aq.pop_front();
            chk("rom_addr", int'(rom_addr), int'(a));
        end
        if (rq.size() == 4) begin
            e = rq.pop_front();
            chk("rgb", int'(rgb), int'(e.rgb));
            chk("hsync_out", int'(hsync_out), int'(e.hs));
            chk("vsync_out", int'(vsync_out), int'(e.vs));
            if (rgb == 3'b111) whites++;
        end
    endtask

    task automatic mstep(
        input int   a1,
        input int   a2,
        input logic hs,
        input logic vs,
        input logic en,
        input logic inv
    );
        logic [2:0]  er;
        logic [10:0] ea;
        model(a1, a2, en, inv, er, ea);
        step(11'(a1), 11'(a2), hs, vs, en, inv, er, ea);
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) mstep(10, 5, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
        rom[0]    = 8'h81;
        rom[1]    = 8'h02;
        rom[16]   = 8'h01;
        rom[2047] = 8'h80;

        tbl[0]  = '{217, 28, 1, 1, 1, 0, 3'b111, 0};
        tbl[1]  = '{224, 28, 1, 1, 1, 0, 3'b111, 0};
        tbl[2]  = '{225, 28, 1, 1, 1, 0, 3'b000, 1};
        tbl[3]  = '{226, 28, 1, 1, 1, 0, 3'b111, 1};
        tbl[4]  = '{217, 29, 1, 1, 1, 0, 3'b111, 16};
        tbl[5]  = '{344, 155, 1, 1, 1, 0, 3'b111, 2047};
        tbl[6]  = '{216, 28, 1, 1, 1, 0, 3'b000, 0};
        tbl[7]  = '{345, 28, 1, 1, 1, 0, 3'b000, 0};
        tbl[8]  = '{217, 27, 1, 1, 1, 0, 3'b000, 0};
        tbl[9]  = '{217, 156, 1, 1, 1, 0, 3'b000, 0};
        tbl[10] = '{217, 28, 1, 1, 0, 0, 3'b000, 0};
        tbl[11] = '{217, 28, 1, 1, 1, 1, 3'b000, 0};
        tbl[12] = '{218, 28, 1, 1, 1, 1, 3'b111, 0};
        tbl[13] = '{10, 28, 0, 1, 1, 0, 3'b000, 0};
        tbl[14] = '{11, 28, 1, 0, 1, 0, 3'b000, 0};
        tbl[15] = '{12, 28, 0, 0, 1, 0, 3'b000, 0};

        #12;
        chk("reset rom_addr", int'(rom_addr), 0);
        chk("reset rgb", int'(rgb), 0);
        chk("reset hsync_out", int'(hsync_out), 1);
        chk("reset vsync_out", int'(vsync_out), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifndef VGA_BITMAP_SCALE2X_EN
        for (int i = 0; i < 16; i++)
            step(tbl[i].c1, tbl[i].c2, tbl[i].hs, tbl[i].vs,
                 tbl[i].en, tbl[i].inv, tbl[i].rgb, tbl[i].addr);
        flush(4);
`else
        mstep(217, 28, 1, 1, 1, 0);
        mstep(218, 28, 1, 1, 1, 0);
        mstep(219, 28, 1, 1, 1, 0);
        mstep(233, 28, 1, 1, 1, 0);
        mstep(472, 28, 1, 1, 1, 0);
        mstep(473, 28, 1, 1, 1, 0);
        mstep(472, 283, 1, 1, 1, 0);
        mstep(472, 284, 1, 1, 1, 0);
        flush(4);
`endif

        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
        for (int a = 216; a <= 216 + WD + 1; a++) mstep(a, 28, 1, 1, 1, 0);
        flush(4);

        for (int i = 0; i < 2048; i++) rom[i] = 8'hFF;
        whites = 0;
        for (int a = 216; a <= 216 + WD + 1; a++) mstep(a, 28, 1, 1, 1, 0);
        flush(4);
        chk("white count", whites, WD);

        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 250; i++)
            mstep(int'($urandom_range(200, 230 + WD)),
                  int'($urandom_range(20, 40 + HD)),
                  1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0), 1'($urandom));
        flush(4);

        for (int a = 217; a < 227; a++) mstep(a, 30, 0, 1, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst rom_addr", int'(rom_addr), 0);
        chk("async rst rgb", int'(rgb), 0);
        chk("async rst hsync_out", int'(hsync_out), 1);
        chk("async rst vsync_out", int'(vsync_out), 1);
        rq.delete();
        aq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int a = 227; a < 250; a++) mstep(a, 31, 1, 0, 1, 0);
        flush(4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
